uart_rx_sequencer: RTL and testbench

//  Control FSM for the UART receive path. Oversamples the RX pin, validates the start bit and

---
 rtl/uart_rx_if.sv | 40 ++++
 rtl/uart_rx_sequencer.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Bundles the UART RX pin, the datapath bit-count feedback and the sequencer's
// control/status strobes. The sequencer uses master; the datapath or bench uses slave.
interface uart_rx_if;
  logic       rx;
  logic [3:0] rx_count;
  logic       rx_sample;
  logic       rx_en;
  logic       rx_rst;
  logic       rx_count_up;
  logic       rx_count_clr;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    input  rx_count,
    output rx_sample,
    output rx_en,
    output rx_rst,
    output rx_count_up,
    output rx_count_clr,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    output rx_count,
    input  rx_sample,
    input  rx_en,
    input  rx_rst,
    input  rx_count_up,
    input  rx_count_clr,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive control FSM: oversamples RX, validates the start bit and sequences an
// external 8-bit SIPO + 4-bit counter through one 8N1 frame, flagging good or bad stop bits.
module uart_rx_sequencer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic       clock,
  input logic       rst_n,
  uart_rx_if.master bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [TCNT_W-1:0] T_HALF   = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] T_FULL   = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] T_ONE    = TCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_sample_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              rx_en_q, rx_en_d;
  logic              rx_rst_q, rx_rst_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_busy_q, rx_busy_d;
  logic              tick;

  // Two-flop synchroniser plus one more stage so rx_sample is stable while rx_en is high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_sample_q <= 1'b1;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      rx_sample_q <= rx_s_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      tcnt_q      <= '0;
      rx_en_q     <= 1'b0;
      rx_rst_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      rx_en_q     <= rx_en_d;
      rx_rst_q    <= rx_rst_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : (div_q + DIV_ONE);
    tcnt_d      = tick ? (tcnt_q + T_ONE) : tcnt_q;
    rx_en_d     = 1'b0;
    rx_rst_d    = 1'b0;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Restart the divider on the falling edge so every later sample lands mid-bit.
        if (!rx_s_q) begin
          state_d = S_START;
          div_d   = '0;
          tcnt_d  = '0;
        end
      end

      S_START: begin
        if (tick && (tcnt_q == T_HALF)) begin
          tcnt_d = '0;
          if (!rx_s_q) begin
            state_d  = S_DATA;
            rx_rst_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tick && (tcnt_q == T_FULL)) begin
          tcnt_d  = '0;
          rx_en_d = 1'b1;
          // rx_count still shows the shifts done before this one, so 7 means this is the last.
          if (bus.rx_count == 4'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (tick && (tcnt_q == T_FULL)) begin
          tcnt_d = '0;
          if (rx_s_q) begin
            state_d    = S_IDLE;
            rx_valid_d = 1'b1;
          end else begin
            state_d     = S_WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  assign bus.rx_sample    = rx_sample_q;
  assign bus.rx_en        = rx_en_q;
  assign bus.rx_count_up  = rx_en_q;
  assign bus.rx_rst       = rx_rst_q;
  assign bus.rx_count_clr = rx_rst_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.rx_busy      = rx_busy_q;

  a_valid_err_exclusive : assert property (
    @(posedge clock) disable iff (!rst_n) !(rx_valid_q && frame_err_q)
  );

  a_rx_en_single_cycle : assert property (
    @(posedge clock) disable iff (!rst_n) rx_en_q |=> !rx_en_q
  );

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench: a frame driver pushes the expected outcome of each frame; a monitor
// with a small datapath model (SIPO + counter) pops and compares on rx_valid/frame_err.
module tb_uart_rx_sequencer;
  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD       = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int BIT        = DIV * OVERSAMPLE;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  uart_rx_if rx_bus ();

  uart_rx_sequencer #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (rx_bus)
  );

  // Datapath that the sequencer controls: LSB-first shift register and bit counter.
  logic [3:0] dp_count;
  logic [7:0] dp_data;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dp_count <= 4'd0;
      dp_data  <= 8'd0;
    end else begin
      if (rx_bus.rx_count_clr)     dp_count <= 4'd0;
      else if (rx_bus.rx_count_up) dp_count <= dp_count + 4'd1;
      if (rx_bus.rx_rst)           dp_data <= 8'd0;
      else if (rx_bus.rx_en)       dp_data <= {rx_bus.rx_sample, dp_data[7:1]};
    end
  end
  assign rx_bus.rx_count = dp_count;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_en = 0, n_rst = 0, n_valid = 0, n_err = 0;
  int     en_in_frame = 0;
  longint cyc = 0;
  longint last_en_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus per-pulse protocol checks.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (rx_bus.rx_en || rx_bus.rx_count_up)
        check("rx_en_vs_count_up", 32'(rx_bus.rx_en), 32'(rx_bus.rx_count_up));
      if (rx_bus.rx_rst || rx_bus.rx_count_clr)
        check("rx_rst_vs_count_clr", 32'(rx_bus.rx_rst), 32'(rx_bus.rx_count_clr));
      if (rx_bus.rx_rst) begin
        n_rst++;
        en_in_frame = 0;
      end
      if (rx_bus.rx_en) begin
        n_en++;
        if (en_in_frame > 0) check("rx_en_spacing", 32'(cyc - last_en_cyc), 32'(BIT));
        last_en_cyc = cyc;
        en_in_frame++;
      end
      if (rx_bus.rx_valid || rx_bus.frame_err) begin
        if (rx_bus.rx_valid) n_valid++;
        if (rx_bus.frame_err) n_err++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {30'd0, rx_bus.rx_valid, rx_bus.frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] frame: data=0x%02h valid=%0b frame_err=%0b (expected data=0x%02h err=%0b)",
                   dp_data, rx_bus.rx_valid, rx_bus.frame_err, e.data, e.is_err);
          check("result_kind", {30'd0, rx_bus.rx_valid, rx_bus.frame_err},
                e.is_err ? 32'd1 : 32'd2);
          check("rx_en_per_frame", 32'(en_in_frame), 32'd8);
          if (!e.is_err) begin
            check("rx_data", 32'(dp_data), 32'(e.data));
            check("rx_count_at_valid", 32'(dp_count), 32'd8);
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame; the line is left at stop_val so callers can stretch a low stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_bits);
    exp_t e;
    e.is_err = ~stop_val;
    e.data   = d;
    exp_q.push_back(e);
    rx_bus.rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_bus.rx = d[i];
      wait_cycles(BIT);
    end
    rx_bus.rx = stop_val;
    wait_cycles(BIT * stop_bits);
  endtask

  int         b_en, b_rst, b_valid, b_err, exp_valid, exp_err;
  logic [7:0] partial;
  logic [7:0] rnd_byte;
  logic       rnd_ok;

  task automatic snap();
    b_en = n_en; b_rst = n_rst; b_valid = n_valid; b_err = n_err;
  endtask

  initial begin
    rx_bus.rx = 1'b1;
    rst_n     = 1'b0;

    // Reset with the line toggling.
    for (int i = 0; i < 6; i++) begin
      rx_bus.rx = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("reset_pulses", {26'd0, rx_bus.rx_en, rx_bus.rx_rst, rx_bus.rx_count_up,
                             rx_bus.rx_count_clr, rx_bus.rx_valid, rx_bus.frame_err}, 32'd0);
      check("reset_busy", 32'(rx_bus.rx_busy), 32'd0);
      check("reset_rx_sample", 32'(rx_bus.rx_sample), 32'd1);
    end
    rx_bus.rx = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(200);
    check("idle_after_reset_busy", 32'(rx_bus.rx_busy), 32'd0);
    check("idle_after_reset_no_rst", 32'(n_rst), 32'd0);

    // Good frame 0xA5.
    snap();
    send_frame(8'hA5, 1'b1, 1);
    wait_cycles(20);
    check("a5_rx_rst_count", 32'(n_rst - b_rst), 32'd1);
    check("a5_rx_en_count", 32'(n_en - b_en), 32'd8);
    check("a5_valid_count", 32'(n_valid - b_valid), 32'd1);
    check("a5_err_count", 32'(n_err - b_err), 32'd0);
    check("a5_busy_after", 32'(rx_bus.rx_busy), 32'd0);

    // Start glitch of three ticks.
    snap();
    rx_bus.rx = 1'b0;
    wait_cycles(3 * DIV);
    rx_bus.rx = 1'b1;
    wait_cycles(600);
    check("glitch_rx_rst", 32'(n_rst - b_rst), 32'd0);
    check("glitch_rx_en", 32'(n_en - b_en), 32'd0);
    check("glitch_valid", 32'(n_valid - b_valid), 32'd0);
    check("glitch_busy", 32'(rx_bus.rx_busy), 32'd0);

    // Framing error: 0x00 with stop bit low for two bit times, then 0x3C.
    snap();
    send_frame(8'h00, 1'b0, 2);
    check("ferr_busy_line_low", 32'(rx_bus.rx_busy), 32'd1);
    check("ferr_err_count", 32'(n_err - b_err), 32'd1);
    check("ferr_valid_count", 32'(n_valid - b_valid), 32'd0);
    rx_bus.rx = 1'b1;
    wait_cycles(20);
    check("ferr_busy_released", 32'(rx_bus.rx_busy), 32'd0);
    wait_cycles(BIT);
    snap();
    send_frame(8'h3C, 1'b1, 1);
    wait_cycles(20);
    check("after_ferr_valid_count", 32'(n_valid - b_valid), 32'd1);

    // Reset after the 4th data bit of 0x5A; nothing is expected from that frame.
    snap();
    partial   = 8'h5A;
    rx_bus.rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_bus.rx = partial[i];
      wait_cycles(BIT);
    end
    check("midreset_en_before", 32'(n_en - b_en), 32'd4);
    rst_n = 1'b0;
    #1;
    check("midreset_pulses", {26'd0, rx_bus.rx_en, rx_bus.rx_rst, rx_bus.rx_count_up,
                              rx_bus.rx_count_clr, rx_bus.rx_valid, rx_bus.frame_err}, 32'd0);
    check("midreset_busy", 32'(rx_bus.rx_busy), 32'd0);
    check("midreset_rx_sample", 32'(rx_bus.rx_sample), 32'd1);
    wait_cycles(3);
    rx_bus.rx = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(BIT);
    check("midreset_no_valid", 32'(n_valid - b_valid), 32'd0);
    check("midreset_no_err", 32'(n_err - b_err), 32'd0);
    snap();
    send_frame(8'hC3, 1'b1, 1);
    wait_cycles(20);
    check("c3_valid_count", 32'(n_valid - b_valid), 32'd1);

    // Back-to-back frames, one stop bit, no gap.
    snap();
    send_frame(8'h12, 1'b1, 1);
    send_frame(8'h34, 1'b1, 1);
    wait_cycles(20);
    check("b2b_valid_count", 32'(n_valid - b_valid), 32'd2);
    check("b2b_rx_en_count", 32'(n_en - b_en), 32'd16);
    check("b2b_err_count", 32'(n_err - b_err), 32'd0);

    // Randomised frames: random byte, random stop-bit level, random idle gap.
    snap();
    exp_valid = 0;
    exp_err   = 0;
    for (int f = 0; f < 2; f++) begin
      rnd_byte = 8'($urandom);
      rnd_ok   = ($urandom_range(0, 3) != 0);
      if (rnd_ok) exp_valid++;
      else        exp_err++;
      send_frame(rnd_byte, rnd_ok, 1);
      rx_bus.rx = 1'b1;
      wait_cycles(int'($urandom_range(4, 200)));
    end
    wait_cycles(20);
    check("rand_valid_count", 32'(n_valid - b_valid), 32'(exp_valid));
    check("rand_err_count", 32'(n_err - b_err), 32'(exp_err));

    // Every expected outcome must have been consumed; bounded wait.
    for (int t = 0; t < 2 * BIT && exp_q.size() != 0; t++) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
